// File: rtl/a2b64_pkg.sv
// Shared types and widths for the ASCII-to-base64 stream encoder.
// State encoding plus fixed symbol, character and accumulator widths.
package a2b64_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        PAD   = 2'd2
    } state_t;

    localparam int          SYM_W    = 6;
    localparam int          CHR_W    = 7;
    localparam int          ACC_W    = 12;
    localparam logic [6:0]  PAD_CHAR = 7'h3D;

endpackage

// File: rtl/a2b64_stream_if.sv
// Character-in / symbol-out stream bundle with valid-ready handshakes on both sides.
// slave is the encoder's view, master is the producer/consumer view.
interface a2b64_stream_if;
    import a2b64_pkg::*;

    logic [CHR_W-1:0] in_char;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [CHR_W-1:0] out_char;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_char, in_valid, in_last, out_ready,
        output in_ready, out_char, out_valid, out_last
    );

    modport master (
        output in_char, in_valid, in_last, out_ready,
        input  in_ready, out_char, out_valid, out_last
    );

endinterface

// File: rtl/b64_lut.sv
// Combinational 6-bit value to base64 ASCII symbol map; zero latency.
// No state and no handshake: purely a lookup used by the encoder output stage.
module b64_lut
    import a2b64_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic [CHR_W-1:0] chr
);

    logic [CHR_W-1:0] s7;

    assign s7 = {1'b0, sym};

    always_comb begin
        chr = '0;
        if (sym < 6'd26) begin
            chr = s7 + 7'h41;
        end else if (sym < 6'd52) begin
            chr = s7 + 7'd71;
        end else if (sym < 6'd62) begin
            chr = s7 - 7'd4;
        end else if (sym == 6'd62) begin
            chr = 7'h2B;
        end else begin
            chr = 7'h2F;
        end
    end

endmodule

// File: rtl/a2b64_stream.sv
// 7-bit ASCII to base64 stream encoder; first symbol one cycle after the filling char; B64_PAD_EN adds '=' padding.
// Backpressure: outputs hold while out_ready=0, and no character is taken while a symbol is pending.
module a2b64_stream
    import a2b64_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    a2b64_stream_if.slave bus
);

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [3:0]         cnt, cnt_n;
`ifdef B64_PAD_EN
    logic [1:0]         mod4, mod4_n;
`endif

    logic               in_xfer, out_xfer;
    logic [SYM_W-1:0]   lut_sym;
    logic [CHR_W-1:0]   lut_chr;
    logic               ov_n, ol_n;
    logic [CHR_W-1:0]   oc_n;
    logic               out_valid_q, out_last_q;
    logic [CHR_W-1:0]   out_char_q;

    // Gated by rst_n so the producer sees no ready while reset is held.
    assign bus.in_ready = rst_n && (state == RUN) && (cnt < 4'd6);
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
        end
    end

`ifdef B64_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod4 <= '0;
        end else begin
            mod4 <= mod4_n;
        end
    end
`endif

    // Unsent bits are kept MSB-aligned; bits below cnt are always zero,
    // which gives the zero-filled final group for free.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
`ifdef B64_PAD_EN
        mod4_n  = mod4;
`endif
        if (in_xfer) begin
            acc_n = acc | ({bus.in_char, 5'b0} >> cnt);
            cnt_n = cnt + 4'd7;
            if (bus.in_last) begin
                state_n = FLUSH;
            end
        end else if (out_xfer) begin
            acc_n = acc << SYM_W;
            cnt_n = (cnt >= 4'd6) ? cnt - 4'd6 : 4'd0;
`ifdef B64_PAD_EN
            mod4_n = mod4 + 2'd1;
`endif
            if (state == FLUSH && cnt_n == 4'd0) begin
`ifdef B64_PAD_EN
                state_n = (mod4_n != 2'd0) ? PAD : RUN;
`else
                state_n = RUN;
`endif
            end
`ifdef B64_PAD_EN
            if (state == PAD && mod4 == 2'd3) begin
                state_n = RUN;
            end
`endif
        end
`ifdef B64_PAD_EN
        if (state_n == RUN && state != RUN) begin
            mod4_n = 2'd0;
        end
`endif
    end

    assign lut_sym = acc_n[ACC_W-1 -: SYM_W];

    b64_lut u_lut (
        .sym (lut_sym),
        .chr (lut_chr)
    );

    // Output registers load the symbol implied by the next state, so they
    // always describe the state the block is about to be in.
    always_comb begin
        ov_n = 1'b0;
        ol_n = 1'b0;
        oc_n = '0;
        case (state_n)
            RUN: begin
                ov_n = (cnt_n >= 4'd6);
            end
            FLUSH: begin
                ov_n = (cnt_n != 4'd0);
`ifdef B64_PAD_EN
                ol_n = (cnt_n <= 4'd6) && (mod4_n == 2'd3);
`else
                ol_n = (cnt_n <= 4'd6);
`endif
            end
`ifdef B64_PAD_EN
            PAD: begin
                ov_n = 1'b1;
                ol_n = (mod4_n == 2'd3);
            end
`endif
            default: begin
                ov_n = 1'b0;
            end
        endcase
        if (ov_n) begin
`ifdef B64_PAD_EN
            oc_n = (state_n == PAD) ? PAD_CHAR : lut_chr;
`else
            oc_n = lut_chr;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_char_q  <= '0;
        end else begin
            out_valid_q <= ov_n;
            out_last_q  <= ol_n;
            out_char_q  <= oc_n;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_char  = out_char_q;

endmodule

// File: tb/tb_a2b64_stream.sv
// Scoreboard bench: expected symbols are queued at stimulus time, a monitor pops on each output transfer.
// Random frames are checked against a bit-string reference encoder.
module tb_a2b64_stream;

    typedef struct {
        logic [6:0] c;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    a2b64_stream_if bus ();

    a2b64_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       expq[$];
    logic [6:0] frame[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_last = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] b64(input int v);
        int r;
        if (v < 26)       r = 65 + v;
        else if (v < 52)  r = 97 + v - 26;
        else if (v < 62)  r = 48 + v - 52;
        else if (v == 62) r = 43;
        else              r = 47;
        return 7'(r);
    endfunction

    task automatic push_str(input string s);
        byte b;
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            e.c = b[6:0];
            e.last = (i == s.len() - 1);
            expq.push_back(e);
        end
    endtask

    // Reference: concatenate 7-bit chars, cut into 6-bit groups, zero-fill, pad.
    task automatic model_frame();
        bit   bits[$];
        logic [6:0] c;
        int   nsym, total, v, idx;
        exp_t e;
        for (int i = 0; i < frame.size(); i++) begin
            c = frame[i];
            for (int b = 6; b >= 0; b--) bits.push_back(c[b]);
        end
        nsym  = (bits.size() + 5) / 6;
        total = nsym;
`ifdef B64_PAD_EN
        total = ((nsym + 3) / 4) * 4;
`endif
        for (int s = 0; s < total; s++) begin
            if (s < nsym) begin
                v = 0;
                for (int k = 0; k < 6; k++) begin
                    idx = s * 6 + k;
                    v = v * 2 + ((idx < bits.size()) ? int'(bits[idx]) : 0);
                end
                e.c = b64(v);
            end else begin
                e.c = 7'h3D;
            end
            e.last = (s == total - 1);
            expq.push_back(e);
        end
    endtask

    task automatic send(input logic [6:0] c, input bit last);
        int guard = 0;
        bus.in_char  = c;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame.size(); i++) begin
            send(frame[i], i == frame.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (expq.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic wait_valid();
        int guard = 0;
        @(negedge clk);
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    // Monitor: compare on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_symbol", 32'(bus.out_char), 32'h0);
                    end else begin
                        e = expq.pop_front();
                        check("sym_char", 32'(bus.out_char), 32'(e.c));
                        check("sym_last", 32'(bus.out_last), 32'(e.last));
                        if (bus.out_last) n_last++;
                    end
                end else if (!bus.out_valid && bus.out_last) begin
                    check("last_without_valid", 32'(bus.out_last), 32'd0);
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] held_c;
        logic       held_l;
        int         last0;
        int         nchar;

        bus.in_char  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_char",  32'(bus.out_char),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single "A"
        rdy_mode = 0;
`ifdef B64_PAD_EN
        push_str("gg==");
`else
        push_str("gg");
`endif
        frame = '{7'h41};
        send_frame(1'b0);
        drain();

        // "AB"
`ifdef B64_PAD_EN
        push_str("gwg=");
`else
        push_str("gwg");
`endif
        frame = '{7'h41, 7'h42};
        send_frame(1'b0);
        drain();

        // Six NULs: 42 bits, seven data symbols
`ifdef B64_PAD_EN
        push_str("AAAAAAA=");
`else
        push_str("AAAAAAA");
`endif
        frame = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        send_frame(1'b0);
        drain();

        // Back-to-back frames
        last0 = n_last;
`ifdef B64_PAD_EN
        push_str("gg==");
        push_str("gwg=");
`else
        push_str("gg");
        push_str("gwg");
`endif
        frame = '{7'h41};
        send_frame(1'b0);
        frame = '{7'h41, 7'h42};
        send_frame(1'b0);
        drain();
        check("b2b_last_count", 32'(n_last - last0), 32'd2);

        // Backpressure: five stalled cycles with a symbol pending
        rdy_mode = 2;
        @(posedge clk);
        #2;
`ifdef B64_PAD_EN
        push_str("gg==");
`else
        push_str("gg");
`endif
        frame = '{7'h41};
        send_frame(1'b0);
        wait_valid();
        held_c = bus.out_char;
        held_l = bus.out_last;
        check("bp_first_char", 32'(held_c), 32'h67);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check("bp_char_hold",  32'(bus.out_char),  32'(held_c));
            check("bp_last_hold",  32'(bus.out_last),  32'(held_l));
            check("bp_in_ready",   32'(bus.in_ready),  32'd0);
        end
        rdy_mode = 0;
        drain();

        // Reset in mid-frame with a symbol pending
        expq.push_back('{7'h2F, 1'b0});
        expq.push_back('{7'h2F, 1'b0});
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b0);
        drain();
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(7'h7F, 1'b0);
        wait_valid();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_char",  32'(bus.out_char),  32'd0);
        check("midrst_out_last",  32'(bus.out_last),  32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_release", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
`ifdef B64_PAD_EN
        push_str("gg==");
`else
        push_str("gg");
`endif
        frame = '{7'h41};
        send_frame(1'b0);
        drain();

        // Random frames under random backpressure
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            frame.delete();
            nchar = $urandom_range(1, 12);
            for (int i = 0; i < nchar; i++) frame.push_back(7'($urandom_range(0, 127)));
            model_frame();
            send_frame(1'b1);
        end
        drain();
        repeat (3) @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
